// File: rtl/axil_selftest_pkg.sv
// Shared types and helpers for the AXI4-Lite register self-test master.
package axil_selftest_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR_DATA,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_CHECK,
        S_FINISH
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    // Width of a vector index; at least one bit so a single-vector sweep still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axil_selftest_vecgen.sv
// Vector generator: running index, address and data accumulators stepped once per vector.
module axil_selftest_vecgen
    import axil_selftest_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_VECTORS = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    ADDR_STRIDE = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] SEED        = 'h0101FFFF,
    parameter logic [DATA_WIDTH-1:0] DATA_STEP   = 'h01010101,
    localparam int                   IW          = idx_width(NUM_VECTORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    output logic                  last,
    output logic [IW-1:0]         index,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    // Accumulators replace i*STRIDE and i*STEP; both wrap naturally at their widths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index <= '0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            index <= '0;
            addr  <= BASE_ADDR;
            data  <= SEED;
        end else if (advance) begin
            index <= index + IW'(1);
            addr  <= addr + ADDR_WIDTH'(ADDR_STRIDE);
            data  <= data + DATA_STEP;
        end
    end

    assign last = (index == IW'(NUM_VECTORS - 1));

endmodule

// File: rtl/axil_reg_selftest.sv
// AXI4-Lite master running a write/read-back/compare sweep over NUM_VECTORS registers.
// Optional per-phase watchdog enabled by defining AXIL_SELFTEST_TIMEOUT_EN.
module axil_reg_selftest
    import axil_selftest_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    NUM_VECTORS    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    ADDR_STRIDE    = DATA_WIDTH / 8,
    parameter logic [DATA_WIDTH-1:0] SEED           = 'h0101FFFF,
    parameter logic [DATA_WIDTH-1:0] DATA_STEP      = 'h01010101,
    parameter int                    TIMEOUT_CYCLES = 256,
    localparam int                   IW             = idx_width(NUM_VECTORS),
    localparam int                   CW             = cnt_width(NUM_VECTORS)
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [CW-1:0]             err_count,
    output logic [IW-1:0]             fail_index,
    output logic                      timeout,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    state_t                state, state_next;
    logic                  load, advance, last;
    logic [IW-1:0]         index;
    logic [ADDR_WIDTH-1:0] vec_addr;
    logic [DATA_WIDTH-1:0] vec_data;
    logic                  aw_done, w_done;
    logic                  wr_err, rd_err;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  vec_fail;
    logic                  tmo_fire;

    axil_selftest_vecgen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_VECTORS(NUM_VECTORS),
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_STRIDE(ADDR_STRIDE),
        .SEED       (SEED),
        .DATA_STEP  (DATA_STEP)
    ) u_vecgen (
        .clk    (ACLK),
        .rst    (ARESET),
        .load   (load),
        .advance(advance),
        .last   (last),
        .index  (index),
        .addr   (vec_addr),
        .data   (vec_data)
    );

    assign load     = (state == S_IDLE) && start;
    assign advance  = (state == S_CHECK) && !last;
    assign vec_fail = (state == S_CHECK) && (wr_err || rd_err || (rdata_q != vec_data));

`ifdef AXIL_SELFTEST_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_cnt;
    logic          wait_state;

    assign wait_state = (state == S_WR_ADDR_DATA) || (state == S_WR_RESP) ||
                        (state == S_RD_ADDR)      || (state == S_RD_DATA);
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        tmo_fire      = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_next = S_WR_ADDR_DATA;
            S_WR_ADDR_DATA: begin
                // AW and W retire independently; leave once both have been accepted.
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
                if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
                    state_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_next = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_next = S_CHECK;
            end
            S_CHECK:  state_next = last ? S_FINISH : S_WR_ADDR_DATA;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
`ifdef AXIL_SELFTEST_TIMEOUT_EN
        // A phase that made no progress for the full window is abandoned.
        if (wait_state && (state_next == state) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
            tmo_fire   = 1'b1;
            state_next = S_FINISH;
        end
`endif
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            wr_err     <= 1'b0;
            rd_err     <= 1'b0;
            err_count  <= '0;
            fail_index <= '0;
            done       <= 1'b0;
        end else begin
            if ((state != S_WR_ADDR_DATA) || (state_next != S_WR_ADDR_DATA)) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
            end
            if ((state == S_WR_RESP) && M_AXI_BVALID) wr_err <= (M_AXI_BRESP != RESP_OKAY);
            if ((state == S_RD_DATA) && M_AXI_RVALID) rd_err <= (M_AXI_RRESP != RESP_OKAY);
            if (load) begin
                err_count  <= '0;
                fail_index <= '0;
                done       <= 1'b0;
            end else begin
                if (vec_fail || tmo_fire) begin
                    if (err_count == '0) fail_index <= index;
                    err_count <= err_count + CW'(1);
                end
                if (state == S_FINISH) done <= 1'b1;
            end
        end
    end

    // Read data is only consumed in CHECK, after it has been captured.
    always_ff @(posedge ACLK) begin
        if ((state == S_RD_DATA) && M_AXI_RVALID) rdata_q <= M_AXI_RDATA;
    end

`ifdef AXIL_SELFTEST_TIMEOUT_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tmo_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            if (state_next != state)                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + TW'(1);
            if (load)          timeout <= 1'b0;
            else if (tmo_fire) timeout <= 1'b1;
        end
    end
`else
    // Without the watchdog the limit has no effect and timeout is constant low.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign busy          = (state != S_IDLE);
    assign pass          = done && (err_count == '0);
    assign M_AXI_AWADDR  = vec_addr;
    assign M_AXI_ARADDR  = vec_addr;
    assign M_AXI_WDATA   = vec_data;
    assign M_AXI_WSTRB   = {(DATA_WIDTH/8){M_AXI_WVALID}};
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;

endmodule

// File: tb/tb_axil_reg_selftest.sv
// Self-checking bench: behavioural AXI4-Lite RAM slave with fault/delay injection and a sweep model.
module tb_axil_reg_selftest;
    import axil_selftest_pkg::*;

    localparam int          NV   = 4;
    localparam logic [31:0] SEED = 32'h0101FFFF;
    localparam logic [31:0] STEP = 32'h01010101;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [2:0]  err_count;
    logic [1:0]  fail_index;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    axil_reg_selftest #(.TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_index(fail_index), .timeout(timeout),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    int tests = 0;
    int fails = 0;

    // Slave behaviour knobs and observation logs.
    bit          rnd, hang_b, st_en;
    int          st_vec;
    bit [NV-1:0] bm, rm;
    logic [31:0] mem [int];
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] rd_addr_q[$];

    function automatic logic [31:0] exp_data(input int i);
        return SEED + 32'(i) * STEP;
    endfunction

    // Expected sweep outcome derived from the injected faults.
    function automatic void model(output int ec, output int fi);
        logic [31:0] d, r;
        ec = 0;
        fi = 0;
        for (int i = 0; i < NV; i++) begin
            d = exp_data(i);
            r = d;
            if (st_en && st_vec == i) r[0] = 1'b0;
            if (bm[i] || rm[i] || r != d) begin
                if (ec == 0) fi = i;
                ec++;
            end
        end
    endfunction

    // Slave decides its outputs on the falling edge, so handshakes are known before the rising edge.
    initial begin : slave
        bit          aw_have, w_have, b_pend, r_pend;
        logic [31:0] aw_addr, w_data, r_data;
        logic [1:0]  b_resp, r_resp;
        int          v;
        aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
        aw_addr = '0; w_data = '0; r_data = '0; b_resp = '0; r_resp = '0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
                continue;
            end
            if (b_pend && !hang_b) begin
                if (!M_AXI_BVALID) M_AXI_BVALID = !rnd || ($urandom_range(0, 2) == 0);
            end else M_AXI_BVALID = 0;
            M_AXI_BRESP = M_AXI_BVALID ? b_resp : 2'b00;
            if (M_AXI_BVALID && M_AXI_BREADY) begin b_pend = 0; b_cnt++; end

            if (r_pend) begin
                if (!M_AXI_RVALID) M_AXI_RVALID = !rnd || ($urandom_range(0, 2) == 0);
            end else M_AXI_RVALID = 0;
            M_AXI_RDATA = M_AXI_RVALID ? r_data : 32'h0;
            M_AXI_RRESP = M_AXI_RVALID ? r_resp : 2'b00;
            if (M_AXI_RVALID && M_AXI_RREADY) begin r_pend = 0; r_cnt++; end

            M_AXI_AWREADY = !aw_have && !b_pend && (!rnd || ($urandom_range(0, 2) == 0));
            M_AXI_WREADY  = !w_have && !b_pend && (!rnd || ($urandom_range(0, 2) == 0));
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin aw_have = 1; aw_addr = M_AXI_AWADDR; aw_cnt++; end
            if (M_AXI_WVALID && M_AXI_WREADY) begin w_have = 1; w_data = M_AXI_WDATA; w_cnt++; end
            if (aw_have && w_have) begin
                mem[int'(aw_addr)] = w_data;
                wr_addr_q.push_back(aw_addr);
                wr_data_q.push_back(w_data);
                v = int'(aw_addr >> 2);
                b_resp = (v < NV && bm[v]) ? 2'b10 : 2'b00;
                b_pend = 1; aw_have = 0; w_have = 0;
            end

            M_AXI_ARREADY = !r_pend && (!rnd || ($urandom_range(0, 2) == 0));
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                ar_cnt++;
                rd_addr_q.push_back(M_AXI_ARADDR);
                v = int'(M_AXI_ARADDR >> 2);
                r_data = mem.exists(int'(M_AXI_ARADDR)) ? mem[int'(M_AXI_ARADDR)] : 32'h0;
                if (st_en && v == st_vec) r_data[0] = 1'b0;
                r_resp = (v < NV && rm[v]) ? 2'b10 : 2'b00;
                r_pend = 1;
            end
        end
    end

    task automatic clear_logs();
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    endtask

    task automatic run_sweep(output int cycles);
        bit ok;
        clear_logs();
        @(negedge ACLK); start = 1;
        @(posedge ACLK); #1 start = 0;
        cycles = 0; ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge ACLK); #1;
            cycles++;
            if (done) begin ok = 1; break; end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL sweep_done: done=%0b after %0d cycles, required 1", done, cycles);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({busy, done, pass, timeout} !== 4'b0) begin
            fails++; $display("FAIL reset_status: busy/done/pass/timeout=%b, required 0000", {busy, done, pass, timeout});
        end
        tests++;
        if (err_count !== 3'd0 || fail_index !== 2'd0) begin
            fails++; $display("FAIL reset_counts: err_count=%0d fail_index=%0d, required 0 0", err_count, fail_index);
        end
        tests++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
            fails++; $display("FAIL reset_handshake: valid/ready=%b, required 00000",
                {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        tests++;
        if (M_AXI_AWADDR !== 32'h0 || M_AXI_ARADDR !== 32'h0 || M_AXI_WDATA !== 32'h0 || M_AXI_WSTRB !== 4'h0) begin
            fails++; $display("FAIL reset_payload: awaddr=%h araddr=%h wdata=%h wstrb=%h, required all 0",
                M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB);
        end
    endtask

    task automatic test_zero_wait();
        int cyc;
        rnd = 0; bm = '0; rm = '0; st_en = 0;
        run_sweep(cyc);
        tests++;
        if (cyc !== 21) begin fails++; $display("FAIL zw_latency: %0d cycles, required 21", cyc); end
        tests++;
        if (pass !== 1'b1 || err_count !== 3'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL zw_result: pass=%0b err_count=%0d busy=%0b, required 1 0 0", pass, err_count, busy);
        end
        tests++;
        if (wr_addr_q.size() !== NV || rd_addr_q.size() !== NV) begin
            fails++; $display("FAIL zw_count: writes=%0d reads=%0d, required %0d", wr_addr_q.size(), rd_addr_q.size(), NV);
        end
        for (int i = 0; i < wr_addr_q.size() && i < NV; i++) begin
            tests++;
            if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== exp_data(i)) begin
                fails++; $display("FAIL zw_write%0d: %h@%h, required %h@%h", i, wr_data_q[i], wr_addr_q[i], exp_data(i), 32'(4 * i));
            end
        end
        tests++;
        if (wr_data_q.size() > 1 && wr_data_q[1] !== 32'h02030100) begin
            fails++; $display("FAIL zw_data1: %h, required 02030100", wr_data_q[1]);
        end
    endtask

    task automatic test_stuck_bit();
        int cyc;
        rnd = 0; bm = '0; rm = '0; st_en = 1; st_vec = 2;
        run_sweep(cyc);
        tests++;
        if (pass !== 1'b0 || err_count !== 3'd1 || fail_index !== 2'd2) begin
            fails++; $display("FAIL stuck_result: pass=%0b err_count=%0d fail_index=%0d, required 0 1 2", pass, err_count, fail_index);
        end
        tests++;
        if (ar_cnt !== NV || wr_addr_q.size() !== NV) begin
            fails++; $display("FAIL stuck_continue: reads=%0d writes=%0d, required %0d", ar_cnt, wr_addr_q.size(), NV);
        end
        st_en = 0;
    endtask

    task automatic test_slverr();
        int cyc;
        rnd = 0; bm = 4'b0010; rm = 4'b1000; st_en = 0;
        run_sweep(cyc);
        tests++;
        if (pass !== 1'b0 || err_count !== 3'd2 || fail_index !== 2'd1) begin
            fails++; $display("FAIL slverr_result: pass=%0b err_count=%0d fail_index=%0d, required 0 2 1", pass, err_count, fail_index);
        end
        bm = '0; rm = '0;
    endtask

    task automatic test_back_to_back();
        int  cyc;
        bit  ok;
        rnd = 0; bm = '0; rm = '0; st_en = 0;
        clear_logs();
        @(negedge ACLK); start = 1;
        @(posedge ACLK); #1 start = 0;
        repeat (6) @(posedge ACLK);
        #1 start = 1;
        @(posedge ACLK); #1 start = 0;
        cyc = 7; ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge ACLK); #1;
            cyc++;
            if (done) begin ok = 1; break; end
        end
        tests++;
        if (!ok || cyc !== 21 || aw_cnt !== NV) begin
            fails++; $display("FAIL start_while_busy: done=%0b cycles=%0d aw=%0d, required 1 21 %0d", ok, cyc, aw_cnt, NV);
        end
        run_sweep(cyc);
        tests++;
        if (cyc !== 21 || pass !== 1'b1 || wr_addr_q.size() !== NV) begin
            fails++; $display("FAIL back_to_back: cycles=%0d pass=%0b writes=%0d, required 21 1 %0d", cyc, pass, wr_addr_q.size(), NV);
        end
    endtask

    task automatic test_random_delays();
        int cyc, ec, fi;
        for (int it = 0; it < 12; it++) begin
            rnd    = 1;
            bm     = ($urandom_range(0, 1) == 1) ? NV'($urandom_range(0, 15)) : '0;
            rm     = ($urandom_range(0, 1) == 1) ? NV'($urandom_range(0, 15)) : '0;
            st_en  = ($urandom_range(0, 1) == 1);
            st_vec = $urandom_range(0, NV - 1);
            model(ec, fi);
            run_sweep(cyc);
            tests++;
            if (err_count !== 3'(ec) || fail_index !== 2'(fi) || pass !== (ec == 0)) begin
                fails++; $display("FAIL rnd%0d_result: err_count=%0d fail_index=%0d pass=%0b, required %0d %0d %0b",
                    it, err_count, fail_index, pass, ec, fi, (ec == 0));
            end
            tests++;
            if (aw_cnt !== NV || w_cnt !== NV || b_cnt !== NV || ar_cnt !== NV || r_cnt !== NV) begin
                fails++; $display("FAIL rnd%0d_handshakes: aw=%0d w=%0d b=%0d ar=%0d r=%0d, required %0d each",
                    it, aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, NV);
            end
            for (int i = 0; i < wr_addr_q.size() && i < NV; i++) begin
                tests++;
                if (wr_addr_q[i] !== 32'(4 * i) || wr_data_q[i] !== exp_data(i) || rd_addr_q.size() <= i
                    || rd_addr_q[i] !== 32'(4 * i)) begin
                    fails++; $display("FAIL rnd%0d_vec%0d: wrote %h@%h, required %h@%h", it, i,
                        wr_data_q[i], wr_addr_q[i], exp_data(i), 32'(4 * i));
                end
            end
        end
        rnd = 0; bm = '0; rm = '0; st_en = 0;
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        bit seen;
        rnd = 1; bm = '0; rm = '0; st_en = 0;
        clear_logs();
        @(negedge ACLK); start = 1;
        @(posedge ACLK); #1 start = 0;
        seen = M_AXI_AWVALID;
        for (int k = 0; k < 50 && !seen; k++) begin @(posedge ACLK); #1; seen = M_AXI_AWVALID; end
        tests++;
        if (seen !== 1'b1) begin fails++; $display("FAIL mid_awvalid: awvalid=%0b, required 1", seen); end
        ARESET = 1;
        #1;
        tests++;
        if ({busy, done, pass, timeout, err_count, fail_index, M_AXI_AWVALID, M_AXI_WVALID,
             M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 14'b0 || M_AXI_AWADDR !== 32'h0 || M_AXI_WDATA !== 32'h0) begin
            fails++; $display("FAIL mid_reset_clear: status=%b awaddr=%h wdata=%h, required all 0",
                {busy, done, pass, timeout, err_count, fail_index, M_AXI_AWVALID, M_AXI_WVALID,
                 M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, M_AXI_AWADDR, M_AXI_WDATA);
        end
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0;
        rnd = 0;
        run_sweep(cyc);
        tests++;
        if (cyc !== 21 || pass !== 1'b1 || wr_addr_q.size() !== NV || (wr_addr_q.size() > 0 && wr_addr_q[0] !== 32'h0)) begin
            fails++; $display("FAIL mid_restart: cycles=%0d pass=%0b writes=%0d, required 21 1 %0d from addr 0",
                cyc, pass, wr_addr_q.size(), NV);
        end
    endtask

    task automatic test_hang();
        bit ok;
        rnd = 0; bm = '0; rm = '0; st_en = 0; hang_b = 1;
        clear_logs();
        @(negedge ACLK); start = 1;
        @(posedge ACLK); #1 start = 0;
`ifdef AXIL_SELFTEST_TIMEOUT_EN
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge ACLK); #1;
            if (done) begin ok = 1; break; end
        end
        tests++;
        if (!ok || timeout !== 1'b1 || pass !== 1'b0 || err_count !== 3'd1) begin
            fails++; $display("FAIL hang_timeout: done=%0b timeout=%0b pass=%0b err_count=%0d, required 1 1 0 1",
                ok, timeout, pass, err_count);
        end
`else
        repeat (60) @(posedge ACLK);
        #1;
        ok = busy;
        tests++;
        if (ok !== 1'b1 || done !== 1'b0 || timeout !== 1'b0) begin
            fails++; $display("FAIL hang_wait: busy=%0b done=%0b timeout=%0b, required 1 0 0", ok, done, timeout);
        end
`endif
        ARESET = 1;
        repeat (2) @(posedge ACLK);
        hang_b = 0;
        #1 ARESET = 0;
    endtask

    initial begin
        ARESET = 1; start = 0;
        rnd = 0; hang_b = 0; st_en = 0; st_vec = 0; bm = '0; rm = '0;
        clear_logs();
        repeat (3) @(posedge ACLK);
        #1;
        test_reset();
        ARESET = 0;
        @(posedge ACLK); #1;
        test_zero_wait();
        test_stuck_bit();
        test_slverr();
        test_back_to_back();
        test_random_delays();
        test_reset_mid_sweep();
        test_hang();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
